// File: rtl/qnet_iq_feature_quantizer.sv
// I/Q sample quantizer and window packer feeding the layer-0 LogicNets LUTs.
// Optional pairwise sample averaging is enabled by defining QNET_IQ_DECIMATE_EN.
module qnet_iq_feature_quantizer #(
    parameter int                         SAMPLE_W    = 16,
    parameter int                         NUM_SAMPLES = 16,
    parameter logic signed [SAMPLE_W-1:0] TH0         = -16'sd1024,
    parameter logic signed [SAMPLE_W-1:0] TH1         = 16'sd0,
    parameter logic signed [SAMPLE_W-1:0] TH2         = 16'sd1024,
    localparam int                        OUT_W       = 4 * NUM_SAMPLES
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [SAMPLE_W-1:0] s_i,
    input  logic signed [SAMPLE_W-1:0] s_q,
    input  logic                       s_first,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [OUT_W-1:0]           m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [1:0]                 err
);

    localparam int             CNT_W    = (NUM_SAMPLES > 2) ? $clog2(NUM_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

    if (NUM_SAMPLES < 2) begin : g_bad_num_samples
        $error("qnet_iq_feature_quantizer: NUM_SAMPLES must be at least 2");
    end
    if ((TH0 > TH1) || (TH1 > TH2)) begin : g_bad_thresholds
        $error("qnet_iq_feature_quantizer: thresholds must satisfy TH0 <= TH1 <= TH2");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [OUT_W-1:0]   vec_r, vec_s;
    logic [OUT_W-1:0]   m_data_r, m_data_s;
    logic               m_valid_r, m_valid_s;
    logic [1:0]         err_r, err_s;
    logic               xfer_s;
    logic               start_s;
    logic               store_s;
    logic [3:0]         code_s;
    logic signed [SAMPLE_W-1:0] qi_s, qq_s;

    // Thermometer count of thresholds at or below x, range 0..3.
    function automatic logic [1:0] quantize(input logic signed [SAMPLE_W-1:0] x);
        return {1'b0, (x >= TH0)} + {1'b0, (x >= TH1)} + {1'b0, (x >= TH2)};
    endfunction

`ifdef QNET_IQ_DECIMATE_EN
    logic                       half_r, half_s;
    logic                       take_half_s;
    logic signed [SAMPLE_W-1:0] hi_r, hi_s, hq_r, hq_s;
    logic signed [SAMPLE_W:0]   sum_i_s, sum_q_s;

    // Floor average of the held first half and the incoming second half.
    assign sum_i_s = $signed({hi_r[SAMPLE_W-1], hi_r}) + $signed({s_i[SAMPLE_W-1], s_i});
    assign sum_q_s = $signed({hq_r[SAMPLE_W-1], hq_r}) + $signed({s_q[SAMPLE_W-1], s_q});
    assign qi_s    = SAMPLE_W'(sum_i_s >>> 1);
    assign qq_s    = SAMPLE_W'(sum_q_s >>> 1);
`else
    assign qi_s    = s_i;
    assign qq_s    = s_q;
`endif

    assign code_s  = {quantize(qq_s), quantize(qi_s)};
    assign s_ready = (state_r != HOLD);
    assign xfer_s  = s_valid && s_ready;
    assign m_data  = m_data_r;
    assign m_valid = m_valid_r;
    assign err     = err_r;

    // Next-state, window assembly and output-register update.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        vec_s     = vec_r;
        m_data_s  = m_data_r;
        m_valid_s = m_valid_r;
        err_s     = 2'b00;
        start_s   = 1'b0;
        store_s   = 1'b0;
`ifdef QNET_IQ_DECIMATE_EN
        half_s      = half_r;
        hi_s        = hi_r;
        hq_s        = hq_r;
        take_half_s = 1'b0;
`endif

        case (state_r)
            IDLE: begin
                if (xfer_s && s_first) begin
                    start_s = 1'b1;
                end else if (xfer_s) begin
                    err_s[1] = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            COLLECT: begin
                // A new s_first mid-window abandons everything collected so far.
                if (xfer_s && s_first) begin
                    start_s  = 1'b1;
                    err_s[0] = 1'b1;
                end else if (xfer_s) begin
`ifdef QNET_IQ_DECIMATE_EN
                    if (half_r) begin
                        store_s = 1'b1;
                    end else begin
                        take_half_s = 1'b1;
                    end
`else
                    store_s = 1'b1;
`endif
                end else begin
                    state_s = COLLECT;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    m_valid_s = 1'b0;
                    state_s   = IDLE;
                end else begin
                    state_s   = HOLD;
                end
            end
            default: begin
                m_valid_s = 1'b0;
                state_s   = IDLE;
            end
        endcase

        if (start_s) begin
            vec_s   = {OUT_W{1'b0}};
            state_s = COLLECT;
`ifdef QNET_IQ_DECIMATE_EN
            hi_s   = s_i;
            hq_s   = s_q;
            half_s = 1'b1;
            cnt_s  = {CNT_W{1'b0}};
`else
            vec_s[3:0] = code_s;
            cnt_s      = CNT_W'(1);
`endif
        end else if (store_s) begin
            vec_s[4*int'(cnt_r) +: 4] = code_s;
`ifdef QNET_IQ_DECIMATE_EN
            half_s = 1'b0;
`endif
            if (cnt_r == LAST_IDX) begin
                m_data_s  = vec_s;
                m_valid_s = 1'b1;
                cnt_s     = {CNT_W{1'b0}};
                state_s   = HOLD;
            end else begin
                cnt_s     = cnt_r + CNT_W'(1);
            end
        end else begin
`ifdef QNET_IQ_DECIMATE_EN
            if (take_half_s) begin
                hi_s   = s_i;
                hq_s   = s_q;
                half_s = 1'b1;
            end else begin
                half_s = half_r;
            end
`else
            cnt_s = cnt_s;
`endif
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            vec_r     <= {OUT_W{1'b0}};
            m_data_r  <= {OUT_W{1'b0}};
            m_valid_r <= 1'b0;
            err_r     <= 2'b00;
`ifdef QNET_IQ_DECIMATE_EN
            half_r    <= 1'b0;
            hi_r      <= {SAMPLE_W{1'b0}};
            hq_r      <= {SAMPLE_W{1'b0}};
`endif
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            vec_r     <= vec_s;
            m_data_r  <= m_data_s;
            m_valid_r <= m_valid_s;
            err_r     <= err_s;
`ifdef QNET_IQ_DECIMATE_EN
            half_r    <= half_s;
            hi_r      <= hi_s;
            hq_r      <= hq_s;
`endif
        end
    end

endmodule

// File: tb/tb_qnet_iq_feature_quantizer.sv
// Directed self-checking bench for qnet_iq_feature_quantizer, NUM_SAMPLES=4.
// Follows QNET_IQ_DECIMATE_EN to pick the matching vector set.
module tb_qnet_iq_feature_quantizer;

    localparam int SW = 16;
    localparam int NS = 4;
    localparam int OW = 4 * NS;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic signed [SW-1:0] s_i;
    logic signed [SW-1:0] s_q;
    logic                 s_first;
    logic                 s_valid;
    logic                 s_ready;
    logic [OW-1:0]        m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [1:0]           err;

    int n_checks = 0;
    int n_errors = 0;

    logic signed [SW-1:0] w1_i [4] = '{-16'sd2000, -16'sd500, 16'sd500, 16'sd2000};
    logic signed [SW-1:0] w1_q [4] = '{16'sd2000, 16'sd500, -16'sd500, -16'sd2000};
    logic signed [SW-1:0] w2_i [4] = '{-16'sd1024, 16'sd0, 16'sd1024, -16'sd1025};
    logic signed [SW-1:0] w2_q [4] = '{16'sd0, 16'sd0, 16'sd0, 16'sd0};

    always #5 clk = ~clk;

    qnet_iq_feature_quantizer #(
        .SAMPLE_W    (SW),
        .NUM_SAMPLES (NS)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_i     (s_i),
        .s_q     (s_q),
        .s_first (s_first),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .err     (err)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic signed [SW-1:0] iv, input logic signed [SW-1:0] qv, input logic f);
        s_i     = iv;
        s_q     = qv;
        s_first = f;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        s_first = 1'b0;
    endtask

    task automatic push_window(input logic signed [SW-1:0] iv [4], input logic signed [SW-1:0] qv [4]);
        for (int k = 0; k < 4; k++) begin
            push(iv[k], qv[k], (k == 0));
            if (k < 3) check_val("valid_early", {31'd0, m_valid}, 32'd0);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        s_i     = 16'sd0;
        s_q     = 16'sd0;
        s_first = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        step();
        step();
        check_val("rst_data",  {16'd0, m_data},  32'd0);
        check_val("rst_valid", {31'd0, m_valid}, 32'd0);
        check_val("rst_err",   {30'd0, err},     32'd0);
        rst_n = 1'b1;
        step();
        check_val("rst_ready", {31'd0, s_ready}, 32'd1);

`ifdef QNET_IQ_DECIMATE_EN
        // Pairs (3,-2)->0 and (-3,-2)->-3 on I; Q pairs average to 0.
        push(16'sd3, 16'sd0, 1'b1);
        push(-16'sd2, 16'sd0, 1'b0);
        push(-16'sd3, 16'sd0, 1'b0);
        push(-16'sd2, 16'sd0, 1'b0);
        push(16'sd2000, 16'sd0, 1'b0);
        push(16'sd2000, 16'sd0, 1'b0);
        push(-16'sd2000, 16'sd0, 1'b0);
        check_val("dec_valid7", {31'd0, m_valid}, 32'd0);
        push(-16'sd2000, 16'sd0, 1'b0);
        check_val("dec_valid8", {31'd0, m_valid}, 32'd1);
        check_val("dec_data",   {16'd0, m_data},  32'h8B9A);
        step();
        check_val("dec_release", {31'd0, m_valid}, 32'd0);

        // s_first on the second of a pair resyncs and drops the half pair.
        push(16'sd100, 16'sd100, 1'b1);
        push(16'sd200, 16'sd200, 1'b1);
        check_val("dec_resync_err", {30'd0, err}, 32'd1);
        for (int n = 0; n < 7; n++) push(16'sd0, 16'sd0, 1'b0);
        check_val("dec_resync_valid", {31'd0, m_valid}, 32'd1);
        check_val("dec_resync_data",  {16'd0, m_data},  32'hAAAA);
        step();

        push(16'sd5, 16'sd5, 1'b0);
        check_val("dec_orphan_err", {30'd0, err}, 32'd2);
        check_val("dec_orphan_valid", {31'd0, m_valid}, 32'd0);
`else
        // Basic window, one code per threshold band.
        push_window(w1_i, w1_q);
        check_val("w1_valid", {31'd0, m_valid}, 32'd1);
        check_val("w1_data",  {16'd0, m_data},  32'h369C);
        check_val("w1_ready", {31'd0, s_ready}, 32'd0);
        step();
        check_val("w1_drop",  {31'd0, m_valid}, 32'd0);
        check_val("w1_rdy1",  {31'd0, s_ready}, 32'd1);

        // Samples exactly on and just below thresholds.
        push_window(w2_i, w2_q);
        check_val("bound_valid", {31'd0, m_valid}, 32'd1);
        check_val("bound_data",  {16'd0, m_data},  32'h8BA9);
        step();

        // Back-pressure: vector held while m_ready is low.
        m_ready = 1'b0;
        push_window(w1_i, w1_q);
        for (int n = 0; n < 5; n++) begin
            check_val("hold_valid", {31'd0, m_valid}, 32'd1);
            check_val("hold_data",  {16'd0, m_data},  32'h369C);
            check_val("hold_ready", {31'd0, s_ready}, 32'd0);
            step();
        end
        m_ready = 1'b1;
        step();
        check_val("hold_release", {31'd0, m_valid}, 32'd0);
        check_val("hold_ready1",  {31'd0, s_ready}, 32'd1);

        // Resync at sample 2.
        push(-16'sd2000, 16'sd2000, 1'b1);
        push(-16'sd500, 16'sd500, 1'b0);
        push(16'sd500, -16'sd500, 1'b1);
        check_val("resync_err", {30'd0, err}, 32'd1);
        push(16'sd2000, -16'sd2000, 1'b0);
        check_val("resync_err_clr", {30'd0, err}, 32'd0);
        push(-16'sd500, 16'sd500, 1'b0);
        check_val("resync_early", {31'd0, m_valid}, 32'd0);
        push(-16'sd2000, 16'sd2000, 1'b0);
        check_val("resync_valid", {31'd0, m_valid}, 32'd1);
        check_val("resync_data",  {16'd0, m_data},  32'hC936);
        step();

        // Orphan sample in IDLE.
        push(16'sd100, 16'sd100, 1'b0);
        check_val("orphan_err",   {30'd0, err},     32'd2);
        check_val("orphan_valid", {31'd0, m_valid}, 32'd0);
        step();
        check_val("orphan_clr",   {30'd0, err},     32'd0);

        // Reset in the middle of a window.
        push(-16'sd2000, 16'sd2000, 1'b1);
        push(-16'sd500, 16'sd500, 1'b0);
        rst_n = 1'b0;
        step();
        check_val("midrst_data",  {16'd0, m_data},  32'd0);
        check_val("midrst_valid", {31'd0, m_valid}, 32'd0);
        check_val("midrst_err",   {30'd0, err},     32'd0);
        rst_n = 1'b1;
        push(16'sd1, 16'sd1, 1'b0);
        check_val("midrst_idle", {30'd0, err}, 32'd2);
        push_window(w2_i, w2_q);
        check_val("clean_valid", {31'd0, m_valid}, 32'd1);
        check_val("clean_data",  {16'd0, m_data},  32'h8BA9);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
